// File: rtl/sarray_store_pkg.sv
// ============================================================================
// sarray_store_pkg : shared widths, FSM states and FIFO entry layout
// Revision 1.0
// ============================================================================
`default_nettype none

package sarray_store_pkg;

    localparam int DATA_W = 512;
    localparam int CNT_W  = 4;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

`default_nettype wire

// File: rtl/sarray_store_fifo.sv
// ============================================================================
// sarray_store_fifo : synchronous first-word-fall-through FIFO
// Revision 1.0
// ============================================================================
`default_nettype none

module sarray_store_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q;
    logic [AW:0]  rd_ptr_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

`default_nettype wire

// File: rtl/sarray_store_collector.sv
// ============================================================================
// sarray_store_collector : buffers systolic-array result rows and issues stores
// Revision 1.0
// ============================================================================
`default_nettype none

module sarray_store_collector #(
    parameter int DATA_W = sarray_store_pkg::DATA_W,
    parameter int CNT_W  = sarray_store_pkg::CNT_W,
    parameter int ADDR_W = sarray_store_pkg::ADDR_W,
    parameter int DEPTH  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cfg_valid_i,
    output logic              cfg_ready_o,
    input  logic [ADDR_W-1:0] cfg_base_i,
    input  logic [ADDR_W-1:0] cfg_stride_i,
    input  logic [CNT_W-1:0]  cfg_rows_m1_i,
    input  logic              bot_valid_i,
    input  logic [CNT_W-1:0]  bot_cnt_i,
    input  logic [DATA_W-1:0] bot_data_i,
    output logic              st_valid_o,
    input  logic              st_ready_i,
    output logic [ADDR_W-1:0] st_addr_o,
    output logic [DATA_W-1:0] st_data_o,
    output logic              busy_o,
    output logic              storec_done_o,
    output logic              err_o
);

    import sarray_store_pkg::*;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, stride_q;
    logic [CNT_W-1:0]    rows_m1_q;
    logic [CNT_W:0]      recv_q, stored_q;
    logic                err_q;

    logic [CNT_W:0]        w_total;
    logic                  w_cfg_take, w_pop, w_push, w_drop, w_excess;
    logic                  w_full, w_empty;
    logic [ADDR_W-1:0]     w_row_addr;
    logic [ADDR_W+DATA_W-1:0] w_din, w_head;

    assign w_total    = {1'b0, rows_m1_q} + {{CNT_W{1'b0}}, 1'b1};
    assign w_cfg_take = (state_q == IDLE) && cfg_valid_i;
    assign w_pop      = !w_empty && st_ready_i;
    assign w_excess   = (recv_q == w_total);
    // A full FIFO still accepts a row when its head leaves in the same cycle.
    assign w_push     = (state_q == ACTIVE) && bot_valid_i && !w_excess &&
                        (!w_full || w_pop);
    assign w_drop     = bot_valid_i && !w_push;
    assign w_row_addr = base_q + ADDR_W'(bot_cnt_i) * stride_q;
    assign w_din      = {w_row_addr, bot_data_i};

    sarray_store_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_din),
        .dout_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign st_valid_o = !w_empty;
    assign st_addr_o  = w_empty ? '0 : w_head[ADDR_W+DATA_W-1:DATA_W];
    assign st_data_o  = w_empty ? '0 : w_head[DATA_W-1:0];
    assign err_o      = err_q;

    always_comb begin
        state_d       = state_q;
        cfg_ready_o   = 1'b0;
        busy_o        = 1'b0;
        storec_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                cfg_ready_o = 1'b1;
                if (cfg_valid_i) state_d = ACTIVE;
            end
            ACTIVE: begin
                busy_o = 1'b1;
                if ((stored_q == w_total) && w_empty) state_d = DONE;
            end
            DONE: begin
                busy_o        = 1'b1;
                storec_done_o = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            base_q    <= '0;
            stride_q  <= '0;
            rows_m1_q <= '0;
            recv_q    <= '0;
            stored_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_cfg_take) begin
                base_q    <= cfg_base_i;
                stride_q  <= cfg_stride_i;
                rows_m1_q <= cfg_rows_m1_i;
                recv_q    <= '0;
                stored_q  <= '0;
            end else begin
                if (w_push) recv_q   <= recv_q + (CNT_W+1)'(1);
                if (w_pop)  stored_q <= stored_q + (CNT_W+1)'(1);
            end
            if (w_drop)          err_q <= 1'b1;
            else if (w_cfg_take) err_q <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sarray_store_collector.sv
// ============================================================================
// tb_sarray_store_collector : directed bench with a queue-based reference model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sarray_store_collector;

    localparam int DW = 512;
    localparam int CW = 4;
    localparam int AW = 32;
    localparam int DP = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [AW-1:0] cfg_base = '0;
    logic [AW-1:0] cfg_stride = '0;
    logic [CW-1:0] cfg_rows_m1 = '0;
    logic          bot_valid = 1'b0;
    logic [CW-1:0] bot_cnt = '0;
    logic [DW-1:0] bot_data = '0;
    logic          st_valid;
    logic          st_ready = 1'b1;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          busy, done, err;

    sarray_store_collector #(
        .DATA_W (DW), .CNT_W (CW), .ADDR_W (AW), .DEPTH (DP)
    ) dut (
        .clk_i (clk), .rst_i (rst),
        .cfg_valid_i (cfg_valid), .cfg_ready_o (cfg_ready),
        .cfg_base_i (cfg_base), .cfg_stride_i (cfg_stride), .cfg_rows_m1_i (cfg_rows_m1),
        .bot_valid_i (bot_valid), .bot_cnt_i (bot_cnt), .bot_data_i (bot_data),
        .st_valid_o (st_valid), .st_ready_i (st_ready),
        .st_addr_o (st_addr), .st_data_o (st_data),
        .busy_o (busy), .storec_done_o (done), .err_o (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: tile status plus a queue of pending {addr,data} rows.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    int            m_state = 0;   // 0 idle, 1 collecting, 2 done pulse
    int            m_recv = 0, m_stored = 0, m_total = 0;
    logic [AW-1:0] m_base = '0, m_stride = '0;
    logic          m_err = 1'b0;
    bit            started = 0;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_state = 0; m_recv = 0; m_stored = 0; m_err = 1'b0;
            started = 1;
        end else begin
            bit   pop, push;
            ent_t e;
            pop  = (mq.size() > 0) && st_ready;
            push = (m_state == 1) && bot_valid && (m_recv < m_total) &&
                   ((mq.size() < DP) || pop);
            e.a = m_base + AW'(bot_cnt) * m_stride;
            e.d = bot_data;
            if (m_state == 0 && cfg_valid) begin
                m_base = cfg_base; m_stride = cfg_stride;
                m_total = int'(cfg_rows_m1) + 1;
                m_recv = 0; m_stored = 0; m_err = 1'b0; m_state = 1;
            end else if (m_state == 1 && m_stored == m_total && mq.size() == 0) begin
                m_state = 2;
            end else if (m_state == 2) begin
                m_state = 0;
            end
            if (bot_valid && !push) m_err = 1'b1;
            if (pop)  begin void'(mq.pop_front()); m_stored++; end
            if (push) begin mq.push_back(e); m_recv++; end
        end
    end

    logic [AW-1:0] st_log[$];
    int            done_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (started) begin
            check("cfg_ready", cfg_ready, (m_state == 0));
            check("busy",      busy,      (m_state != 0));
            check("done",      done,      (m_state == 2));
            check("err",       err,       m_err);
            check("st_valid",  st_valid,  (mq.size() != 0));
            check("st_addr",   st_addr,   (mq.size() != 0) ? mq[0].a : '0);
            check("st_data",   st_data,   (mq.size() != 0) ? mq[0].d : '0);
            if (st_valid && st_ready) st_log.push_back(st_addr);
            if (done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [CW-1:0] r);
        cfg_base = b; cfg_stride = s; cfg_rows_m1 = r; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic row(input int c);
        bot_valid = 1'b1;
        bot_cnt   = CW'(c);
        bot_data  = {16{$urandom}};
        tick();
        bot_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!cfg_ready && n < 200) begin tick(); n++; end
        check({name, "_timeout"}, (n < 200), 1'b1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1;
        tick(); tick();
        rst = 1'b0;
        check("reset_cfg_ready", cfg_ready, 1'b1);
        check("reset_st_valid",  st_valid,  1'b0);
        check("reset_err",       err,       1'b0);

        // Basic tile
        st_log.delete(); done_cnt = 0;
        do_cfg(32'h1000, 32'h40, 4'd3);
        for (int i = 0; i < 4; i++) row(i);
        wait_idle("basic");
        check("basic_n",  st_log.size(), 4);
        check("basic_a0", st_log[0], 32'h1000);
        check("basic_a1", st_log[1], 32'h1040);
        check("basic_a2", st_log[2], 32'h1080);
        check("basic_a3", st_log[3], 32'h10C0);
        check("basic_done_cnt", done_cnt, 1);
        check("basic_err", err, 1'b0);

        // Backpressure: six stalled cycles
        st_log.delete(); done_cnt = 0;
        do_cfg(32'h1000, 32'h40, 4'd3);
        st_ready = 1'b0;
        for (int i = 0; i < 4; i++) row(i);
        tick(); tick();
        check("bp_head", st_addr, 32'h1000);
        st_ready = 1'b1;
        wait_idle("bp");
        check("bp_n",  st_log.size(), 4);
        check("bp_a3", st_log[3], 32'h10C0);
        check("bp_done_cnt", done_cnt, 1);

        // Overflow: ninth row into a full FIFO with no pop
        st_ready = 1'b0;
        do_cfg(32'h2000, 32'h40, 4'd15);
        for (int i = 0; i < 8; i++) row(i);
        check("ovf_err_before", err, 1'b0);
        row(8);
        check("ovf_err", err, 1'b1);
        pulse_reset();
        check("ovf_rst_ready", cfg_ready, 1'b1);

        // Same fill, but the ninth row meets a pop
        st_log.delete(); done_cnt = 0;
        do_cfg(32'h2000, 32'h40, 4'd15);
        for (int i = 0; i < 8; i++) row(i);
        st_ready = 1'b1;
        row(8);
        check("ovf_pop_err", err, 1'b0);
        for (int i = 9; i < 16; i++) row(i);
        wait_idle("ovf2");
        check("ovf2_n",   st_log.size(), 16);
        check("ovf2_a15", st_log[15], 32'h23C0);
        check("ovf2_done_cnt", done_cnt, 1);
        check("ovf2_err", err, 1'b0);

        // Stray row in IDLE, then excess row in a tile
        st_log.delete(); done_cnt = 0;
        row(0);
        tick(); tick();
        check("stray_err", err, 1'b1);
        check("stray_no_store", st_log.size(), 0);
        do_cfg(32'h3000, 32'h40, 4'd3);
        check("cfg_clears_err", err, 1'b0);
        for (int i = 0; i < 4; i++) row(i);
        row(3);
        check("excess_err", err, 1'b1);
        wait_idle("excess");
        check("excess_n", st_log.size(), 4);
        check("excess_sticky", err, 1'b1);

        // Address wrap
        st_log.delete();
        do_cfg(32'hFFFF_FFC0, 32'h40, 4'd1);
        check("wrap_err_clr", err, 1'b0);
        row(0); row(1);
        wait_idle("wrap");
        check("wrap_a0", st_log[0], 32'hFFFF_FFC0);
        check("wrap_a1", st_log[1], 32'h0000_0000);

        // Reset mid-tile
        done_cnt = 0;
        st_ready = 1'b0;
        do_cfg(32'h4000, 32'h40, 4'd3);
        row(0); row(1);
        check("mid_buffered", st_valid, 1'b1);
        pulse_reset();
        check("mid_st_valid", st_valid, 1'b0);
        check("mid_cfg_ready", cfg_ready, 1'b1);
        st_ready = 1'b1;
        repeat (5) tick();
        check("mid_no_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
